// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_pkg
//  Purpose  : Shared definitions for the register file: clear-sweep FSM state
//             encoding and the address-width derivation function.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package register_file_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clear_state_e;

  // Address width for a given register count; never below one bit.
  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_clear_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rf_clear_sequencer
//  Purpose  : Sweep FSM that zeroes every register, one index per cycle, after
//             a clear request. A sweep lasts exactly DEPTH cycles.
//  Ports    : clock      - rising-edge clock
//             reset      - synchronous active-low reset (aborts a sweep)
//             clear_req  - one-cycle request; ignored while a sweep runs
//             busy       - registered, high for every cycle spent sweeping
//             clear_en   - this cycle's edge zeroes register clear_addr
//             clear_addr - register index being zeroed
//  Revision : 1.0 - initial release
// ============================================================================
module rf_clear_sequencer
  import register_file_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_req,
  output logic          busy,
  output logic          clear_en,
  output logic [AW-1:0] clear_addr
);

  localparam logic [AW-1:0] LAST_INDEX = AW'(DEPTH - 1);

  clear_state_e  state, state_next;
  logic [AW-1:0] index, index_next;

  always_comb begin
    state_next = state;
    index_next = index;
    clear_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          index_next = '0;
        end
      end
      ST_CLEAR: begin
        // clear_req is deliberately not examined here: no restart mid-sweep.
        clear_en = 1'b1;
        if (index == LAST_INDEX) begin
          state_next = ST_IDLE;
          index_next = '0;
        end else begin
          index_next = index + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        index_next = '0;
      end
    endcase
  end

  assign clear_addr = index;

  // busy is registered from the next state so it tracks CLEAR exactly.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
      index <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      index <= index_next;
      busy  <= (state_next == ST_CLEAR);
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module   : register_file
//  Purpose  : Flip-flop register file, one write port and two registered read
//             ports, optional write-to-read forwarding, and a sweep clear.
//  Ports    : clock, reset (sync active-low)
//             write_en / write_addr / write_data       - write port
//             read_en_a / read_addr_a -> read_data_a   - read port A
//             read_en_b / read_addr_b -> read_data_b   - read port B
//             clear_req - start a zeroing sweep; busy - sweep in progress
//  Revision : 1.0 - initial release
// ============================================================================
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int BYPASS = 1,
  parameter int AW     = calc_aw(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_en,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_en_a,
  input  logic [AW-1:0]    read_addr_a,
  output logic [WIDTH-1:0] read_data_a,
  input  logic             read_en_b,
  input  logic [AW-1:0]    read_addr_b,
  output logic [WIDTH-1:0] read_data_b,
  input  logic             clear_req,
  output logic             busy
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];

  logic          clear_en;
  logic [AW-1:0] clear_addr;
  logic          write_ok;
  logic          wr_in_range, a_in_range, b_in_range;
  logic [WIDTH-1:0] next_a, next_b;

  rf_clear_sequencer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clock      (clock),
    .reset      (reset),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_en   (clear_en),
    .clear_addr (clear_addr)
  );

  // Extra leading zero so a power-of-two DEPTH compares correctly.
  assign wr_in_range = ({1'b0, write_addr}  < DEPTH_W);
  assign a_in_range  = ({1'b0, read_addr_a} < DEPTH_W);
  assign b_in_range  = ({1'b0, read_addr_b} < DEPTH_W);

  // A clear request in IDLE beats a simultaneous write.
  assign write_ok = write_en && !busy && !clear_req && wr_in_range;

  always_comb begin
    next_a = '0;
    if (a_in_range) begin
      if ((BYPASS != 0) && write_ok && (write_addr == read_addr_a)) begin
        next_a = write_data;
      end else begin
        next_a = regs[read_addr_a];
      end
    end
  end

  always_comb begin
    next_b = '0;
    if (b_in_range) begin
      if ((BYPASS != 0) && write_ok && (write_addr == read_addr_b)) begin
        next_b = write_data;
      end else begin
        next_b = regs[read_addr_b];
      end
    end
  end

  // write_ok is never true during a sweep, so the two updates cannot collide.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (clear_en) begin
        regs[clear_addr] <= '0;
      end
      if (write_ok) begin
        regs[write_addr] <= write_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      read_data_a <= '0;
      read_data_b <= '0;
    end else begin
      if (read_en_a) read_data_a <= next_a;
      if (read_en_b) read_data_b <= next_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file
//  Purpose  : Self-checking bench. Three register files share one stimulus:
//             [0] defaults, [1] BYPASS=0, [2] DEPTH=5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;

  logic       clock = 1'b0;
  logic       reset;
  logic       write_en, read_en_a, read_en_b, clear_req;
  logic [2:0] write_addr, read_addr_a, read_addr_b;
  logic [7:0] write_data;

  logic [7:0] rda [3];
  logic [7:0] rdb [3];
  logic       bsy [3];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int         depth_m [3] = '{8, 8, 5};
  bit         byp_m   [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] mem_m   [3][8];
  logic [7:0] exa     [3];
  logic [7:0] exb     [3];
  int         left_m  [3];   // sweep cycles remaining

  always #5 clock = ~clock;

  register_file u_dut (
    .clock(clock), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .read_en_a(read_en_a), .read_addr_a(read_addr_a),
    .read_data_a(rda[0]), .read_en_b(read_en_b), .read_addr_b(read_addr_b),
    .read_data_b(rdb[0]), .clear_req(clear_req), .busy(bsy[0]));

  register_file #(.BYPASS(0)) u_nb (
    .clock(clock), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .read_en_a(read_en_a), .read_addr_a(read_addr_a),
    .read_data_a(rda[1]), .read_en_b(read_en_b), .read_addr_b(read_addr_b),
    .read_data_b(rdb[1]), .clear_req(clear_req), .busy(bsy[1]));

  register_file #(.DEPTH(5)) u_d5 (
    .clock(clock), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .read_en_a(read_en_a), .read_addr_a(read_addr_a),
    .read_data_a(rda[2]), .read_en_b(read_en_b), .read_addr_b(read_addr_b),
    .read_data_b(rdb[2]), .clear_req(clear_req), .busy(bsy[2]));

  // Behavioural model: applied at each rising edge using pre-edge contents.
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      bit busy_now, wok;
      if (!reset) begin
        for (int j = 0; j < 8; j++) mem_m[k][j] = 8'h00;
        exa[k] = 8'h00; exb[k] = 8'h00; left_m[k] = 0;
      end else begin
        busy_now = (left_m[k] > 0);
        wok = write_en && !busy_now && !clear_req && (int'(write_addr) < depth_m[k]);
        if (read_en_a)
          exa[k] = (int'(read_addr_a) >= depth_m[k]) ? 8'h00 :
                   (byp_m[k] && wok && write_addr == read_addr_a) ? write_data :
                   mem_m[k][read_addr_a];
        if (read_en_b)
          exb[k] = (int'(read_addr_b) >= depth_m[k]) ? 8'h00 :
                   (byp_m[k] && wok && write_addr == read_addr_b) ? write_data :
                   mem_m[k][read_addr_b];
        if (busy_now) begin
          mem_m[k][depth_m[k] - left_m[k]] = 8'h00;
          left_m[k] = left_m[k] - 1;
        end else if (clear_req) begin
          left_m[k] = depth_m[k];
        end
        if (wok) mem_m[k][write_addr] = write_data;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic quiet();
    reset = 1'b1; write_en = 1'b0; read_en_a = 1'b0; read_en_b = 1'b0;
    clear_req = 1'b0; write_addr = '0; read_addr_a = '0; read_addr_b = '0;
    write_data = '0;
  endtask

  task automatic test_reset();
    quiet();
    reset = 1'b0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rda[k] !== 8'h00 || rdb[k] !== 8'h00 || bsy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset dut%0d: a=%h b=%h busy=%b, required 00 00 0", k, rda[k], rdb[k], bsy[k]);
      end
    end
    quiet();
  endtask

  task automatic test_write_read();
    quiet();
    write_en = 1'b1; write_addr = 3'd3; write_data = 8'hA5;
    tick();
    quiet();
    read_en_a = 1'b1; read_addr_a = 3'd3;
    tick();
    quiet();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rda[k] !== 8'hA5) begin
        miscompares++;
        $display("FAIL write_read dut%0d: got %h, required a5", k, rda[k]);
      end
    end
  endtask

  task automatic test_collision();
    quiet();
    write_en = 1'b1; write_addr = 3'd2; write_data = 8'h11;
    tick();
    write_data = 8'h3C; read_en_b = 1'b1; read_addr_b = 3'd2;
    read_en_a = 1'b1; read_addr_a = 3'd2;
    tick();
    quiet();
    vectors++;
    if (rdb[0] !== 8'h3C || rda[0] !== 8'h3C) begin
      miscompares++;
      $display("FAIL bypass_on: a=%h b=%h, required 3c 3c", rda[0], rdb[0]);
    end
    vectors++;
    if (rdb[1] !== 8'h11 || rda[1] !== 8'h11) begin
      miscompares++;
      $display("FAIL bypass_off: a=%h b=%h, required 11 11", rda[1], rdb[1]);
    end
  endtask

  task automatic test_out_of_range();
    quiet();
    write_en = 1'b1; write_addr = 3'd6; write_data = 8'hFF;
    tick();
    write_addr = 3'd4; write_data = 8'h44;
    tick();
    quiet();
    read_en_a = 1'b1; read_addr_a = 3'd6; read_en_b = 1'b1; read_addr_b = 3'd4;
    tick();
    quiet();
    vectors++;
    if (rda[2] !== 8'h00 || rdb[2] !== 8'h44) begin
      miscompares++;
      $display("FAIL depth5_range: a(6)=%h b(4)=%h, required 00 44", rda[2], rdb[2]);
    end
    vectors++;
    if (rda[0] !== 8'hFF) begin
      miscompares++;
      $display("FAIL depth8_addr6: got %h, required ff", rda[0]);
    end
  endtask

  task automatic test_clear();
    int cnt [3];
    quiet();
    for (int j = 0; j < 8; j++) begin
      write_en = 1'b1; write_addr = 3'(j); write_data = 8'h10 + 8'(j);
      tick();
    end
    // Clear and write in the same cycle: the clear must win.
    clear_req = 1'b1; write_en = 1'b1; write_addr = 3'd5; write_data = 8'hEE;
    tick();
    quiet();
    for (int k = 0; k < 3; k++) begin
      cnt[k] = bsy[k] ? 1 : 0;
      vectors++;
      if (bsy[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL clear_busy_rise dut%0d: busy=%b, required 1", k, bsy[k]);
      end
    end
    for (int c = 0; c < 12; c++) begin
      quiet();
      if (c >= 1 && c <= 3) begin
        write_en = 1'b1; write_addr = 3'd0; write_data = 8'hEE;
      end
      if (c == 2) clear_req = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) if (bsy[k]) cnt[k]++;
    end
    quiet();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (cnt[k] !== depth_m[k]) begin
        miscompares++;
        $display("FAIL clear_busy_len dut%0d: %0d cycles, required %0d", k, cnt[k], depth_m[k]);
      end
    end
    for (int j = 0; j < 8; j++) begin
      quiet();
      read_en_a = 1'b1; read_addr_a = 3'(j); read_en_b = 1'b1; read_addr_b = 3'(7 - j);
      tick();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (rda[k] !== 8'h00 || rdb[k] !== 8'h00) begin
          miscompares++;
          $display("FAIL clear_zero dut%0d r%0d: a=%h b=%h, required 00 00", k, j, rda[k], rdb[k]);
        end
      end
    end
    quiet();
  endtask

  task automatic test_reset_mid_sweep();
    quiet();
    write_en = 1'b1; write_addr = 3'd4; write_data = 8'h5A;
    tick();
    quiet();
    read_en_a = 1'b1; read_addr_a = 3'd4; read_en_b = 1'b1; read_addr_b = 3'd4;
    tick();
    quiet();
    clear_req = 1'b1;
    tick();
    quiet();
    tick(); tick(); tick();
    reset = 1'b0; read_en_a = 1'b1; read_addr_a = 3'd4;
    tick();
    quiet();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bsy[k] !== 1'b0 || rda[k] !== 8'h00 || rdb[k] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_mid_sweep dut%0d: busy=%b a=%h b=%h, required 0 00 00", k, bsy[k], rda[k], rdb[k]);
      end
    end
    write_en = 1'b1; write_addr = 3'd7; write_data = 8'h77;
    tick();
    quiet();
    read_en_a = 1'b1; read_addr_a = 3'd7;
    tick();
    quiet();
    tick();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rda[k] !== ((k == 2) ? 8'h00 : 8'h77) || bsy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_r7 dut%0d: a=%h busy=%b, required %h 0", k, rda[k], bsy[k], (k == 2) ? 8'h00 : 8'h77);
      end
    end
  endtask

  task automatic test_hold();
    quiet();
    write_en = 1'b1; write_addr = 3'd1; write_data = 8'h21;
    tick();
    quiet();
    read_en_a = 1'b1; read_addr_a = 3'd1;
    tick();
    for (int c = 0; c < 10; c++) begin
      quiet();
      read_addr_a = 3'd1;
      write_en = 1'b1; write_addr = 3'd1; write_data = 8'($urandom_range(0, 255));
      tick();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (rda[k] !== 8'h21) begin
          miscompares++;
          $display("FAIL hold dut%0d cycle %0d: got %h, required 21", k, c, rda[k]);
        end
      end
    end
    quiet();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(0, 63) != 0);
      clear_req   = ($urandom_range(0, 15) == 0);
      write_en    = 1'($urandom);
      write_addr  = 3'($urandom);
      write_data  = 8'($urandom);
      read_en_a   = 1'($urandom);
      read_addr_a = 3'($urandom);
      read_en_b   = 1'($urandom);
      read_en_b   = read_en_b | ($urandom_range(0, 3) == 0);
      read_addr_b = ($urandom_range(0, 2) == 0) ? write_addr : 3'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (rda[k] !== exa[k] || rdb[k] !== exb[k] || bsy[k] !== (left_m[k] > 0)) begin
          miscompares++;
          $display("FAIL random dut%0d cycle %0d: a=%h b=%h busy=%b, required %h %h %b",
                   k, c, rda[k], rdb[k], bsy[k], exa[k], exb[k], (left_m[k] > 0));
        end
      end
    end
    quiet();
  endtask

  initial begin
    quiet();
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_collision();
    test_out_of_range();
    test_clear();
    test_reset_mid_sweep();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 8, data width of every register and data port.
REQ-002 Parameter DEPTH, default 8, number of registers; legal range 2..256.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write forwarded to a read port, 0 = read returns old contents.
REQ-004 Derived constant AW = ceil(log2(DEPTH)), address width.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset, sampled on rising clock.
REQ-007 write_en  input  1  write request for the current cycle.
REQ-008 write_addr  input  AW  register index to write.
REQ-009 write_data  input  WIDTH  value to store.
REQ-010 read_en_a  input  1  port A read request.
REQ-011 read_addr_a  input  AW  port A register index.
REQ-012 read_data_a  output  WIDTH  port A registered read value.
REQ-013 read_en_b  input  1  port B read request.
REQ-014 read_addr_b  input  AW  port B register index.
REQ-015 read_data_b  output  WIDTH  port B registered read value.
REQ-016 clear_req  input  1  one-cycle request to zero all registers.
REQ-017 busy  output  1  registered; high while a clear sweep runs.

Function
REQ-018 Write: write_en=1 and busy=0 at a rising edge SHALL store write_data into register write_addr.
REQ-019 Read: read_en_x=1 at a rising edge SHALL load read_data_x with register read_addr_x (1-cycle latency); read_en_x=0 SHALL hold read_data_x.
REQ-020 Ports A and B SHALL operate independently, including the same address in the same cycle.
REQ-021 Read/write collision, same address, write accepted: BYPASS=1 -> read_data_x = write_data; BYPASS=0 -> read_data_x = pre-write contents.
REQ-022 Address >= DEPTH: writes SHALL be dropped; reads SHALL load 0.
REQ-023 FSM states IDLE and CLEAR; clear_req=1 in IDLE -> CLEAR with sweep index 0.
REQ-024 In CLEAR, each cycle SHALL zero register[index] and increment index; after index DEPTH-1 is zeroed -> IDLE, so a sweep takes exactly DEPTH cycles.
REQ-025 busy SHALL be 1 exactly in the DEPTH cycles the FSM is in CLEAR, rising the cycle after clear_req is sampled.
REQ-026 clear_req in CLEAR SHALL be ignored (no restart).
REQ-027 write_en with busy=1 SHALL be dropped; write_en and clear_req sampled together in IDLE: clear wins, write dropped.
REQ-028 Reads during CLEAR SHALL be served and return current contents (already-zeroed or not yet zeroed); no bypass from the sweep.

Reset
REQ-029 reset=0 at a rising edge SHALL zero every register, read_data_a, read_data_b, busy and sweep index, and force IDLE.
REQ-030 Reset SHALL take priority over write, read and clear, including mid-sweep (sweep aborted).

Structure
REQ-031 FSM state encoding and the AW derivation function SHALL live in shared package register_file_pkg.
REQ-032 The sweep FSM and index counter SHALL be sub-module rf_clear_sequencer (outputs busy, clear_en, clear_addr).
REQ-033 Storage SHALL be flip-flops, no inferred RAM macros, so the clear sweep and reset apply uniformly.

Verification
REQ-034 Defaults; write 0xA5 to r3, then read A r3 -> read_data_a = 0xA5 one cycle after read_en_a.
REQ-035 BYPASS=1: same cycle write r2=0x3C and read B r2 -> read_data_b = 0x3C; repeat with BYPASS=0, r2 previously 0x11 -> 0x11.
REQ-036 Fill r0..r7 with 0x10..0x17, pulse clear_req -> busy high exactly 8 cycles, writes during busy dropped, then all reads return 0x00.
REQ-037 DEPTH=5: write 0xFF to address 6 then read address 6 -> 0x00; address 4 behaves normally.
REQ-038 Reset low at sweep cycle 3 -> next cycle busy=0, both read outputs 0, state IDLE; subsequent write/read of r7 works.
REQ-039 Hold read_en_a=0 for 10 cycles while writing the addressed register -> read_data_a unchanged.
